// File: rtl/dual_issue_unit.sv
// dual_issue_unit: steers fetched instruction pairs to even/odd pipes, splitting pairs on register or structural hazards.
module dual_issue_unit #(
  parameter int WORD = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] instr1,
  input  logic [WORD-1:0] instr2,
  input  logic            instr1_odd,
  input  logic            instr2_odd,
  input  logic            hold,
  input  logic            flush,
  output logic            dep_stall_instr2,
  output logic [WORD-1:0] even_instr,
  output logic            even_valid,
  output logic [WORD-1:0] odd_instr,
  output logic            odd_valid,
  output logic [CNTW-1:0] split_count
);
  typedef enum logic [1:0] {START, PAIR, SECOND} state_t;
  localparam logic [WORD-1:0] even_nop = WORD'(32'h4020_0000);
  localparam logic [WORD-1:0] odd_nop  = WORD'(32'h0020_0000);
  state_t state;
  logic [WORD-1:0] cap;
  logic cap_odd;
  logic nop1, nop2, raw, split, pair_go, sec_go, iss1, iss2;
  logic e1, e2, e3, o1, o2, o3;
  // Bit 0 of the big-endian encoding is the MSB, so opcode [0:10] sits at the top.
  assign nop1 = instr1[WORD-1 -: 11] == 11'b01000000001 || instr1[WORD-1 -: 11] == 11'b00000000001;
  assign nop2 = instr2[WORD-1 -: 11] == 11'b01000000001 || instr2[WORD-1 -: 11] == 11'b00000000001;
  assign raw = instr1[6:0] == instr2[WORD-12 -: 7] || instr1[6:0] == instr2[WORD-19 -: 7]
            || instr1[6:0] == instr2[6:0];
  assign split = !nop1 && !nop2 && (raw || instr1_odd == instr2_odd);
  assign pair_go = state == PAIR && !flush && !hold;
  assign sec_go = state == SECOND && !flush && !hold;
  assign iss1 = pair_go && !nop1;
  assign iss2 = pair_go && !nop2 && !split;
  assign e1 = iss1 && !instr1_odd;
  assign e2 = iss2 && !instr2_odd;
  assign e3 = sec_go && !cap_odd;
  assign o1 = iss1 && instr1_odd;
  assign o2 = iss2 && instr2_odd;
  assign o3 = sec_go && cap_odd;
  assign dep_stall_instr2 = !flush && ((state == PAIR && (hold || split)) || (state == SECOND && hold));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= START;
      even_valid <= 1'b0;
      odd_valid <= 1'b0;
      even_instr <= even_nop;
      odd_instr <= odd_nop;
      split_count <= '0;
      cap <= '0;
      cap_odd <= 1'b0;
    end else begin
      even_valid <= e1 || e2 || e3;
      odd_valid <= o1 || o2 || o3;
      even_instr <= e1 ? instr1 : e2 ? instr2 : e3 ? cap : even_nop;
      odd_instr <= o1 ? instr1 : o2 ? instr2 : o3 ? cap : odd_nop;
      state <= state == START ? PAIR : flush ? START : state == PAIR ? (hold || !split ? PAIR : SECOND)
             : hold ? SECOND : PAIR;
      if (pair_go && split) begin
        cap <= instr2;
        cap_odd <= instr2_odd;
        if (split_count != '1) split_count <= split_count + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dual_issue_unit.sv
// tb_dual_issue_unit: directed checks of pair issue, hazard splits, nop dropping, hold, flush and reset.
module tb_dual_issue_unit;
  logic clk = 0, reset = 1;
  logic [31:0] instr1 = 0, instr2 = 0;
  logic instr1_odd = 0, instr2_odd = 0, hold = 0, flush = 0;
  logic dep_stall_instr2, even_valid, odd_valid;
  logic [31:0] even_instr, odd_instr, split_count;
  int n_checks = 0, n_fail = 0;

  localparam logic [31:0] ENOP = 32'h4020_0000, ONOP = 32'h0020_0000;
  localparam logic [31:0] A5 = 32'h1800_0005, B123 = 32'h1800_4103;
  localparam logic [31:0] A7 = 32'h1800_0007, B_RA7 = 32'h1800_4382;

  dual_issue_unit dut (
    .clk(clk), .reset(reset), .instr1(instr1), .instr2(instr2),
    .instr1_odd(instr1_odd), .instr2_odd(instr2_odd), .hold(hold), .flush(flush),
    .dep_stall_instr2(dep_stall_instr2), .even_instr(even_instr), .even_valid(even_valid),
    .odd_instr(odd_instr), .odd_valid(odd_valid), .split_count(split_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic ao, input logic [31:0] b, input logic bo);
    instr1 = a; instr1_odd = ao; instr2 = b; instr2_odd = bo;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(A5, 0, B123, 1);
    tick(); tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got e=%b o=%b want 0 0", even_valid, odd_valid); end
    n_checks++; if (even_instr !== ENOP || odd_instr !== ONOP) begin n_fail++; $display("FAIL reset_instr: got %h %h want %h %h", even_instr, odd_instr, ENOP, ONOP); end
    n_checks++; if (split_count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", split_count); end
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", dep_stall_instr2); end
    reset = 0;
    #1;
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL start_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL start_no_issue: got e=%b o=%b want 0 0", even_valid, odd_valid); end
  endtask

  task automatic test_clean_pair();
    drive(A5, 0, B123, 1);
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL clean_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b1 || even_instr !== A5) begin n_fail++; $display("FAIL clean_even: got v=%b %h want 1 %h", even_valid, even_instr, A5); end
    n_checks++; if (odd_valid !== 1'b1 || odd_instr !== B123) begin n_fail++; $display("FAIL clean_odd: got v=%b %h want 1 %h", odd_valid, odd_instr, B123); end
  endtask

  task automatic test_raw_split();
    drive(A7, 0, B_RA7, 1);
    n_checks++; if (dep_stall_instr2 !== 1'b1) begin n_fail++; $display("FAIL raw_stall_n: got %b want 1", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b1 || even_instr !== A7 || odd_valid !== 1'b0 || odd_instr !== ONOP) begin n_fail++; $display("FAIL raw_first: got e=%b %h o=%b %h want 1 %h 0 %h", even_valid, even_instr, odd_valid, odd_instr, A7, ONOP); end
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL raw_stall_n1: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (odd_valid !== 1'b1 || odd_instr !== B_RA7 || even_valid !== 1'b0 || even_instr !== ENOP) begin n_fail++; $display("FAIL raw_second: got e=%b %h o=%b %h want 0 %h 1 %h", even_valid, even_instr, odd_valid, odd_instr, ENOP, B_RA7); end
    n_checks++; if (split_count !== 1) begin n_fail++; $display("FAIL raw_count: got %0d want 1", split_count); end
  endtask

  task automatic test_struct_split();
    drive(A5, 1, B123, 1);
    n_checks++; if (dep_stall_instr2 !== 1'b1) begin n_fail++; $display("FAIL struct_stall: got %b want 1", dep_stall_instr2); end
    tick();
    n_checks++; if (odd_valid !== 1'b1 || odd_instr !== A5 || even_valid !== 1'b0) begin n_fail++; $display("FAIL struct_first: got o=%b %h e=%b want 1 %h 0", odd_valid, odd_instr, even_valid, A5); end
    tick();
    n_checks++; if (odd_valid !== 1'b1 || odd_instr !== B123 || even_valid !== 1'b0) begin n_fail++; $display("FAIL struct_second: got o=%b %h e=%b want 1 %h 0", odd_valid, odd_instr, even_valid, B123); end
    n_checks++; if (split_count !== 2) begin n_fail++; $display("FAIL struct_count: got %0d want 2", split_count); end
  endtask

  task automatic test_nops();
    drive(ONOP, 1, B123, 0);
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL nop_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b1 || even_instr !== B123 || odd_valid !== 1'b0 || odd_instr !== ONOP) begin n_fail++; $display("FAIL nop_one: got e=%b %h o=%b %h want 1 %h 0 %h", even_valid, even_instr, odd_valid, odd_instr, B123, ONOP); end
    drive(ENOP, 0, ONOP, 0);
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL nop_pair_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL nop_pair: got e=%b o=%b want 0 0", even_valid, odd_valid); end
  endtask

  task automatic test_hold_flush();
    drive(A5, 0, B123, 1);
    hold = 1; #1;
    n_checks++; if (dep_stall_instr2 !== 1'b1) begin n_fail++; $display("FAIL hold_pair_stall: got %b want 1", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL hold_pair_issue: got e=%b o=%b want 0 0", even_valid, odd_valid); end
    hold = 0;
    drive(A7, 0, B_RA7, 1);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (dep_stall_instr2 !== 1'b1) begin n_fail++; $display("FAIL hold_sec_stall[%0d]: got %b want 1", i, dep_stall_instr2); end
      tick();
      n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL hold_sec_issue[%0d]: got e=%b o=%b want 0 0", i, even_valid, odd_valid); end
    end
    hold = 0; #1;
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL hold_release_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (odd_valid !== 1'b1 || odd_instr !== B_RA7 || even_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_issue: got o=%b %h e=%b want 1 %h 0", odd_valid, odd_instr, even_valid, B_RA7); end
    n_checks++; if (split_count !== 3) begin n_fail++; $display("FAIL hold_count: got %0d want 3", split_count); end
    tick();
    flush = 1; hold = 1; #1;
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL flush_sec_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_sec_issue: got e=%b o=%b want 0 0", even_valid, odd_valid); end
    flush = 0; hold = 0; #1;
    n_checks++; if (dep_stall_instr2 !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall: got %b want 0", dep_stall_instr2); end
    tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0 || split_count !== 4) begin n_fail++; $display("FAIL flush_start: got e=%b o=%b cnt=%0d want 0 0 4", even_valid, odd_valid, split_count); end
    n_checks++; if (dep_stall_instr2 !== 1'b1) begin n_fail++; $display("FAIL flush_back_pair: got %b want 1", dep_stall_instr2); end
  endtask

  task automatic test_reset_in_second();
    tick();
    n_checks++; if (even_valid !== 1'b1 || even_instr !== A7 || split_count !== 5) begin n_fail++; $display("FAIL rst2_first: got e=%b %h cnt=%0d want 1 %h 5", even_valid, even_instr, split_count, A7); end
    reset = 1;
    tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0 || split_count !== 0) begin n_fail++; $display("FAIL rst2_discard: got e=%b o=%b cnt=%0d want 0 0 0", even_valid, odd_valid, split_count); end
    reset = 0;
    drive(ENOP, 0, ONOP, 1);
    tick(); tick();
    n_checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_no_stale: got e=%b o=%b want 0 0", even_valid, odd_valid); end
  endtask

  task automatic test_back_to_back();
    drive(A5, 0, B123, 1);
    tick();
    drive(B123, 1, A5, 0);
    n_checks++; if (even_instr !== A5 || odd_instr !== B123) begin n_fail++; $display("FAIL b2b_first: got %h %h want %h %h", even_instr, odd_instr, A5, B123); end
    tick();
    n_checks++; if (even_valid !== 1'b1 || even_instr !== A5 || odd_valid !== 1'b1 || odd_instr !== B123) begin n_fail++; $display("FAIL b2b_second: got e=%b %h o=%b %h want 1 %h 1 %h", even_valid, even_instr, odd_valid, odd_instr, A5, B123); end
  endtask

  initial begin
    test_reset();
    test_clean_pair();
    test_raw_split();
    test_struct_split();
    test_nops();
    test_hold_flush();
    test_reset_in_second();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
